// File: rtl/xadc_drp_arbiter_pkg.sv
// Shared types and constants for the XADC DRP arbiter: DRP bus widths,
// arbiter FSM states, XADC register addresses and the pointer-wrap helper.
package xadc_drp_arbiter_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // XADC status and configuration register addresses commonly polled or written
  typedef enum logic [6:0] {
    XREG_TEMP    = 7'h00,
    XREG_VCCINT  = 7'h01,
    XREG_VCCAUX  = 7'h02,
    XREG_VPVN    = 7'h03,
    XREG_VCCBRAM = 7'h06,
    XREG_VAUX0   = 7'h10,
    XREG_VAUX1   = 7'h11,
    XREG_VAUX2   = 7'h12,
    XREG_VAUX3   = 7'h13,
    XREG_VAUX8   = 7'h18,
    XREG_CFG0    = 7'h40,
    XREG_CFG1    = 7'h41,
    XREG_CFG2    = 7'h42
  } xadc_reg_e;

  // Round-robin successor of a requester index, wrapping at n
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/xadc_drp_arbiter_if.sv
// Bundles the requester handshake and the XADC DRP bus. The arbiter uses
// the slave view; requesters plus the XADC primitive form the master side.
interface xadc_drp_arbiter_if #(
  parameter int NUM_REQ = 3
) ();
  import xadc_drp_arbiter_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [DRP_AW*NUM_REQ-1:0] req_addr;
  logic [DRP_DW*NUM_REQ-1:0] req_di;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_err;
  logic [DRP_DW-1:0]         rd_data;
  logic [DRP_AW-1:0]         drp_daddr;
  logic                      drp_den;
  logic                      drp_dwe;
  logic [DRP_DW-1:0]         drp_di;
  logic [DRP_DW-1:0]         drp_do;
  logic                      drp_drdy;
  logic                      arb_busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_di, drp_do, drp_drdy,
    output req_ack, req_err, rd_data, drp_daddr, drp_den, drp_dwe, drp_di, arb_busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_di, drp_do, drp_drdy,
    input  req_ack, req_err, rd_data, drp_daddr, drp_den, drp_dwe, drp_di, arb_busy
  );

endinterface

// File: rtl/xadc_drp_arbiter_rr.sv
// Combinational round-robin picker: the first requesting index at or after
// the pointer (wrapping) wins. Returns the grant one-hot and as an index.
module xadc_drp_arbiter_rr #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  // Scan NUM_REQ positions starting at the pointer; only the first hit is kept
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] sel;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[sel]) begin
        found          = 1'b1;
        gnt_oh_o[sel]  = 1'b1;
        gnt_idx_o      = sel;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Shares one XADC DRP port between NUM_REQ requesters. One transaction in
// flight, round-robin service, DRDY timeout per transaction. All outputs
// come straight from registers.
module xadc_drp_arbiter
  import xadc_drp_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic               DCLK,
  input logic               RESET,
  xadc_drp_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [DRP_DW-1:0]  rd_data_q, rd_data_d;
  logic [DRP_DW-1:0]  di_q, di_d;
  logic [DRP_AW-1:0]  daddr_q, daddr_d;
  logic               den_q, den_d;
  logic               dwe_q, dwe_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [DRP_AW-1:0]  sel_addr;
  logic [DRP_DW-1:0]  sel_di;
  logic               sel_we;

  xadc_drp_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  // One-hot mux of the picked requester's fields; nobody else's are used
  always_comb begin
    sel_addr = '0;
    sel_di   = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr = bus.req_addr[i*DRP_AW +: DRP_AW];
        sel_di   = bus.req_di[i*DRP_DW +: DRP_DW];
        sel_we   = bus.req_we[i];
      end
    end
  end

  // FSM next state, DRP strobes, completion pulses and timeout counter
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_oh_d  = gnt_oh_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    err_d     = '0;
    rd_data_d = rd_data_q;
    daddr_d   = daddr_q;
    di_d      = di_q;
    den_d     = 1'b0;
    dwe_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          gnt_d    = pick_idx;
          gnt_oh_d = pick_oh;
          daddr_d  = sel_addr;
          di_d     = sel_di;
          // DEN/DWE are registered, so raising them here lands them in ISSUE
          den_d    = 1'b1;
          dwe_d    = sel_we;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // DRDY is checked first so it wins over a coincident timeout
        if (bus.drp_drdy) begin
          rd_data_d = bus.drp_do;
          ack_d     = gnt_oh_q;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = gnt_oh_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = IDX_W'(rr_next(int'(gnt_q), NUM_REQ));
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, pointer, latched request and registered outputs
  always_ff @(posedge DCLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_oh_q  <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rd_data_q <= '0;
      daddr_q   <= '0;
      di_q      <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_oh_q  <= gnt_oh_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.req_err   = err_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.drp_daddr = daddr_q;
  assign bus.drp_den   = den_q;
  assign bus.drp_dwe   = dwe_q;
  assign bus.drp_di    = di_q;
  assign bus.arb_busy  = busy_q;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Testbench for xadc_drp_arbiter: XADC register-file model with scheduled
// DRDY, round-robin reference model and per-feature test tasks.
module tb_xadc_drp_arbiter;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xadc_drp_arbiter_if #(.NUM_REQ(3)) bus ();

  xadc_drp_arbiter #(.NUM_REQ(3), .TIMEOUT(TO), .CNT_W(8)) dut (
    .DCLK  (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // environment / model state
  event        tick;
  int          cyc = 0;
  logic [15:0] mem [128];
  int          den_cnt = 0, den_cyc = 0, cur_delay = 0;
  logic [6:0]  den_addr;
  logic        den_we;
  logic [15:0] den_di;
  logic [2:0]  den_valid;
  bit          pend = 0;
  int          delay = 3;
  bit          rand_delay = 0;
  int          stray_at = -1;
  int          ev_cnt = 0, ev_cyc = 0;
  logic [2:0]  ev_ack, ev_err;
  logic [15:0] ev_rd;
  int          dwe_alone = 0;
  int          ref_ptr = 0;
  logic [6:0]  fa [3];
  logic        fw [3];
  logic [15:0] fd [3];

  // Reference round-robin rule: first pending requester at or after p
  function automatic int rr_pick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) if (v[(p + k) % 3]) return (p + k) % 3;
    return 0;
  endfunction

  // XADC model and observer, evaluated mid-cycle on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cyc == 1) begin
      for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);
      mem[0] = 16'hB5E0;
    end
    if (!rst_n) ref_ptr = 0;
    if (bus.drp_den) begin
      den_cnt++;
      den_cyc   = cyc;
      den_addr  = bus.drp_daddr;
      den_we    = bus.drp_dwe;
      den_di    = bus.drp_di;
      den_valid = bus.req_valid;
      if (bus.drp_dwe) mem[bus.drp_daddr] = bus.drp_di;
      cur_delay = rand_delay ? int'($urandom_range(1, 6)) : delay;
      pend      = (cur_delay > 0);
    end
    if (bus.drp_dwe && !bus.drp_den) dwe_alone++;
    if ((bus.req_ack | bus.req_err) != 3'b000) begin
      ev_cnt++;
      ev_ack = bus.req_ack;
      ev_err = bus.req_err;
      ev_cyc = cyc;
      ev_rd  = bus.rd_data;
      for (int i = 0; i < 3; i++)
        if (bus.req_ack[i] || bus.req_err[i]) ref_ptr = (i + 1) % 3;
    end
    bus.drp_drdy = 1'b0;
    bus.drp_do   = 16'h0000;
    if (stray_at == cyc) begin
      bus.drp_drdy = 1'b1;
      bus.drp_do   = 16'hDEAD;
    end
    if (pend && cyc == den_cyc + cur_delay) begin
      bus.drp_drdy = 1'b1;
      bus.drp_do   = den_we ? 16'($urandom) : mem[den_addr];
      pend         = 1'b0;
    end
    -> tick;
  end

  task automatic set_req(input int i, input bit we, input logic [6:0] a, input logic [15:0] d);
    bus.req_we[i]          = we;
    bus.req_addr[7*i +: 7] = a;
    bus.req_di[16*i +: 16] = d;
    bus.req_valid[i]       = 1'b1;
    fa[i] = a; fw[i] = we; fd[i] = d;
  endtask

  task automatic drop_done();
    bus.req_valid = bus.req_valid & ~(ev_ack | ev_err);
  endtask

  task automatic wait_den(output bit ok);
    int n0;
    n0 = den_cnt; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(tick);
      if (den_cnt != n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ev(output bit ok);
    int n0;
    n0 = ev_cnt; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(tick);
      if (ev_cnt != n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(tick);
    checks++; if ({bus.req_ack, bus.req_err} !== 6'b0) $display("FAIL reset_ack_err: got %b want 000000", {bus.req_ack, bus.req_err}); else passed++;
    checks++; if (bus.rd_data !== 16'h0) $display("FAIL reset_rd_data: got %h want 0000", bus.rd_data); else passed++;
    checks++; if ({bus.drp_daddr, bus.drp_den, bus.drp_dwe, bus.drp_di} !== 25'h0) $display("FAIL reset_drp: got %h want 0", {bus.drp_daddr, bus.drp_den, bus.drp_dwe, bus.drp_di}); else passed++;
    checks++; if (bus.arb_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.arb_busy); else passed++;
    rst_n = 1'b1;
    repeat (2) @(tick);
  endtask

  task automatic test_single_read();
    bit ok; int c0, d0;
    delay = 3; d0 = den_cnt;
    set_req(0, 1'b0, 7'h00, 16'h0);
    c0 = cyc;
    wait_den(ok);
    checks++; if (!ok || den_cyc != c0 + 1) $display("FAIL read_den_latency: got %0d want %0d", den_cyc, c0 + 1); else passed++;
    checks++; if ({den_addr, den_we} !== {7'h00, 1'b0}) $display("FAIL read_addr_we: got %h/%b want 00/0", den_addr, den_we); else passed++;
    wait_ev(ok);
    checks++; if (!ok || {ev_err, ev_ack} !== 6'b000001) $display("FAIL read_ack: got %b want 000001", {ev_err, ev_ack}); else passed++;
    checks++; if (ev_cyc != den_cyc + 4) $display("FAIL read_ack_latency: got %0d want %0d", ev_cyc, den_cyc + 4); else passed++;
    checks++; if (ev_rd !== 16'hB5E0) $display("FAIL read_data: got %h want b5e0", ev_rd); else passed++;
    drop_done();
    @(tick);
    checks++; if (bus.req_ack !== 3'b000 || den_cnt - d0 != 1) $display("FAIL read_pulses: got ack %b dens %0d want 000 1", bus.req_ack, den_cnt - d0); else passed++;
  endtask

  task automatic test_write();
    bit ok; int d0;
    delay = int'($urandom_range(1, 5)); d0 = den_cnt;
    set_req(1, 1'b1, 7'h40, 16'h1000);
    wait_den(ok);
    checks++; if (!ok || {den_we, den_addr, den_di} !== {1'b1, 7'h40, 16'h1000}) $display("FAIL write_drp: got %b %h %h want 1 40 1000", den_we, den_addr, den_di); else passed++;
    bus.req_valid[1] = 1'b0;  // requester gives up mid-transaction
    wait_ev(ok);
    checks++; if (!ok || {ev_err, ev_ack} !== 6'b000010) $display("FAIL write_ack: got %b want 000010", {ev_err, ev_ack}); else passed++;
    checks++; if (den_cnt - d0 != 1 || dwe_alone != 0) $display("FAIL write_strobes: got dens %0d lone_dwe %0d want 1 0", den_cnt - d0, dwe_alone); else passed++;
    drop_done();
    @(tick);
  endtask

  task automatic test_round_robin();
    bit ok; int exp, prev;
    rand_delay = 1'b1; prev = -1;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 7'(8'h10 + i), 16'h0);
    for (int n = 0; n < 6; n++) begin
      wait_den(ok);
      exp = rr_pick(den_valid, ref_ptr);
      checks++; if (!ok || den_addr !== fa[exp] || exp == prev) $display("FAIL rr_cont_grant%0d: got addr %h want %h", n, den_addr, fa[exp]); else passed++;
      wait_ev(ok);
      checks++; if (!ok || {ev_err, ev_ack} !== {3'b000, 3'(1 << exp)} || ev_rd !== mem[fa[exp]]) $display("FAIL rr_cont_done%0d: got %b/%h want %b/%h", n, {ev_err, ev_ack}, ev_rd, 3'(1 << exp), mem[fa[exp]]); else passed++;
      prev = exp;
    end
    bus.req_valid = 3'b000;
    @(tick);
    for (int n = 0; n < 16; n++) begin
      if (bus.req_valid == 3'b000) set_req(int'($urandom_range(0, 2)), 1'($urandom), 7'($urandom), 16'($urandom));
      wait_den(ok);
      exp = rr_pick(den_valid, ref_ptr);
      checks++; if (!ok || {den_addr, den_we} !== {fa[exp], fw[exp]} || (fw[exp] && den_di !== fd[exp])) $display("FAIL rr_rand_grant%0d: got %h/%b want %h/%b", n, den_addr, den_we, fa[exp], fw[exp]); else passed++;
      wait_ev(ok);
      checks++; if (!ok || {ev_err, ev_ack} !== {3'b000, 3'(1 << exp)} || (!fw[exp] && ev_rd !== mem[fa[exp]])) $display("FAIL rr_rand_done%0d: got %b/%h want %b/%h", n, {ev_err, ev_ack}, ev_rd, 3'(1 << exp), mem[fa[exp]]); else passed++;
      drop_done();
      for (int i = 0; i < 3; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, 1'($urandom), 7'($urandom), 16'($urandom));
    end
    rand_delay = 1'b0;
    bus.req_valid = 3'b000;
    repeat (8) @(tick);
  endtask

  task automatic test_timeout();
    bit ok;
    delay = -1;
    set_req(2, 1'b0, 7'h03, 16'h0);
    wait_den(ok);
    wait_ev(ok);
    checks++; if (!ok || {ev_err, ev_ack} !== 6'b100000) $display("FAIL timeout_err: got %b want 100000", {ev_err, ev_ack}); else passed++;
    checks++; if (ev_cyc != den_cyc + TO + 2) $display("FAIL timeout_latency: got %0d want %0d", ev_cyc - den_cyc, TO + 2); else passed++;
    drop_done();
    delay = 2;
    set_req(0, 1'b0, 7'h02, 16'h0);
    wait_den(ok);
    wait_ev(ok);
    checks++; if (!ok || {ev_err, ev_ack} !== 6'b000001 || ev_rd !== mem[7'h02]) $display("FAIL timeout_recover: got %b/%h want 000001/%h", {ev_err, ev_ack}, ev_rd, mem[7'h02]); else passed++;
    drop_done();
    @(tick);
  endtask

  task automatic test_stale_drdy();
    bit ok; int e0, c0;
    e0 = ev_cnt;
    stray_at = cyc + 2;
    repeat (5) @(tick);
    checks++; if (ev_cnt != e0 || bus.arb_busy !== 1'b0) $display("FAIL stale_idle: got events %0d busy %b want 0 0", ev_cnt - e0, bus.arb_busy); else passed++;
    delay = 5;
    set_req(0, 1'b0, 7'h01, 16'h0);
    c0 = cyc; stray_at = c0 + 1;  // lands in the ISSUE cycle
    wait_den(ok);
    wait_ev(ok);
    checks++; if (!ok || {ev_err, ev_ack} !== 6'b000001 || ev_cyc != den_cyc + 6 || ev_rd !== mem[7'h01]) $display("FAIL stale_issue: got %b cyc+%0d %h want 000001 cyc+6 %h", {ev_err, ev_ack}, ev_cyc - den_cyc, ev_rd, mem[7'h01]); else passed++;
    drop_done();
    delay = TO + 1;
    set_req(2, 1'b0, 7'h06, 16'h0);
    wait_den(ok);
    wait_ev(ok);
    checks++; if (!ok || {ev_err, ev_ack} !== 6'b000100 || ev_cyc != den_cyc + TO + 2) $display("FAIL drdy_vs_timeout: got %b cyc+%0d want 000100 cyc+%0d", {ev_err, ev_ack}, ev_cyc - den_cyc, TO + 2); else passed++;
    drop_done();
    delay = TO + 2;  // DRDY arrives in DONE after the timeout
    set_req(1, 1'b0, 7'h18, 16'h0);
    wait_den(ok);
    wait_ev(ok);
    checks++; if (!ok || {ev_err, ev_ack} !== 6'b010000) $display("FAIL late_drdy_err: got %b want 010000", {ev_err, ev_ack}); else passed++;
    drop_done();
    e0 = ev_cnt;
    repeat (4) @(tick);
    checks++; if (ev_cnt != e0 || bus.arb_busy !== 1'b0) $display("FAIL late_drdy_ignored: got events %0d busy %b want 0 0", ev_cnt - e0, bus.arb_busy); else passed++;
  endtask

  task automatic test_reset_midtxn();
    bit ok; int exp;
    delay = -1;
    set_req(0, 1'b0, 7'h11, 16'h0);
    set_req(2, 1'b1, 7'h42, 16'hA5A5);
    wait_den(ok);
    exp = rr_pick(den_valid, ref_ptr);
    checks++; if (!ok || den_addr !== fa[exp]) $display("FAIL rst_pre_grant: got %h want %h", den_addr, fa[exp]); else passed++;
    repeat (3) @(tick);
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.req_ack, bus.req_err, bus.arb_busy} !== 7'b0) $display("FAIL rst_async_ctrl: got %b want 0000000", {bus.req_ack, bus.req_err, bus.arb_busy}); else passed++;
    checks++; if ({bus.drp_daddr, bus.drp_den, bus.drp_dwe, bus.drp_di, bus.rd_data} !== 41'h0) $display("FAIL rst_async_data: got %h want 0", {bus.drp_daddr, bus.drp_den, bus.drp_dwe, bus.drp_di, bus.rd_data}); else passed++;
    @(tick);
    rst_n = 1'b1;
    delay = 3;
    for (int n = 0; n < 2; n++) begin
      wait_den(ok);
      exp = rr_pick(den_valid, ref_ptr);
      checks++; if (!ok || den_addr !== fa[exp]) $display("FAIL rst_post_grant%0d: got %h want %h", n, den_addr, fa[exp]); else passed++;
      wait_ev(ok);
      checks++; if (!ok || {ev_err, ev_ack} !== {3'b000, 3'(1 << exp)}) $display("FAIL rst_post_ack%0d: got %b want %b", n, {ev_err, ev_ack}, 3'(1 << exp)); else passed++;
      drop_done();
    end
    @(tick);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_di    = '0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_timeout();
    test_stale_drdy();
    test_reset_midtxn();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
